minute_hour_counter: RTL and testbench

// - Downstream of the seconds stage: consumes its change_minute strobe and keeps BCD minutes and hours.
// - Provides a time-set mode in which user button strobes step minutes/hours directly.
// - Emits change_day on midnight roll-over; feeds the display mux and the alarm comparator.

---
 rtl/minute_hour_counter_if.sv | 24 ++
 rtl/minute_hour_counter.sv | 138 +++++++++++++
 tb/tb_minute_hour_counter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/minute_hour_counter_if.sv
// Handshake bundle between the seconds stage/buttons and the minute/hour counter.
// Master drives strobes and mode; slave returns BCD digits and the day strobe.
interface minute_hour_counter_if;
   logic       change_minute;
   logic       set_mode;
   logic       inc_min;
   logic       inc_hr;
   logic [3:0] right_min;
   logic [3:0] left_min;
   logic [3:0] right_hr;
   logic [3:0] left_hr;
   logic       pm;
   logic       change_day;

   modport master (
      output change_minute, set_mode, inc_min, inc_hr,
      input  right_min, left_min, right_hr, left_hr, pm, change_day
   );

   modport slave (
      input  change_minute, set_mode, inc_min, inc_hr,
      output right_min, left_min, right_hr, left_hr, pm, change_day
   );
endinterface

// File: rtl/minute_hour_counter.sv
// BCD minute/hour counter with run/set modes and midnight day strobe.
// Hour sequence is 00..23 or 12..11 with AM/PM, chosen by MODE_24H.
module minute_hour_counter #(
   parameter bit MODE_24H = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   minute_hour_counter_if.slave bus
);

   typedef enum logic {RUN, SET} state_t;

   state_t     state;
   logic       cm_q, im_q, ih_q;
   logic       cm_ev, im_ev, ih_ev;
   logic [3:0] rm, lm, rh, lh;
   logic       pm_q, day_q;

   logic [3:0] m_rm, m_lm;
   logic       m_wrap;
   logic [3:0] h_rh, h_lh;
   logic       h_pm, h_day;

   assign cm_ev = bus.change_minute & ~cm_q;
   assign im_ev = bus.inc_min & ~im_q;
   assign ih_ev = bus.inc_hr & ~ih_q;

   assign bus.right_min  = rm;
   assign bus.left_min   = lm;
   assign bus.right_hr   = rh;
   assign bus.left_hr    = lh;
   assign bus.pm         = pm_q;
   assign bus.change_day = day_q;

   always_comb begin
      m_rm   = rm + 4'd1;
      m_lm   = lm;
      m_wrap = 1'b0;
      if (rm == 4'd9) begin
         m_rm = 4'd0;
         if (lm == 4'd5) begin
            m_lm   = 4'd0;
            m_wrap = 1'b1;
         end else begin
            m_lm = lm + 4'd1;
         end
      end
   end

   // Next hour along the sequence; h_day flags the midnight crossing.
   always_comb begin
      h_rh  = rh + 4'd1;
      h_lh  = lh;
      h_pm  = pm_q;
      h_day = 1'b0;
      if (MODE_24H) begin
         unique case (1'b1)
            (lh == 4'd2 && rh == 4'd3): begin
               h_lh  = 4'd0;
               h_rh  = 4'd0;
               h_day = 1'b1;
            end
            (rh == 4'd9): begin
               h_lh = lh + 4'd1;
               h_rh = 4'd0;
            end
            default: ;
         endcase
      end else begin
         unique case (1'b1)
            (lh == 4'd1 && rh == 4'd2): begin
               h_lh = 4'd0;
               h_rh = 4'd1;
            end
            (lh == 4'd1 && rh == 4'd1): begin
               h_lh  = 4'd1;
               h_rh  = 4'd2;
               h_pm  = ~pm_q;
               h_day = pm_q;
            end
            (rh == 4'd9): begin
               h_lh = 4'd1;
               h_rh = 4'd0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
         cm_q  <= 1'b0;
         im_q  <= 1'b0;
         ih_q  <= 1'b0;
         rm    <= 4'd0;
         lm    <= 4'd0;
         rh    <= MODE_24H ? 4'd0 : 4'd2;
         lh    <= MODE_24H ? 4'd0 : 4'd1;
         pm_q  <= 1'b0;
         day_q <= 1'b0;
      end else begin
         cm_q  <= bus.change_minute;
         im_q  <= bus.inc_min;
         ih_q  <= bus.inc_hr;
         day_q <= 1'b0;
         unique case (state)
            RUN: begin
               if (cm_ev) begin
                  rm <= m_rm;
                  lm <= m_lm;
                  if (m_wrap) begin
                     rh    <= h_rh;
                     lh    <= h_lh;
                     pm_q  <= h_pm;
                     day_q <= h_day;
                  end
               end
               if (bus.set_mode) state <= SET;
            end
            SET: begin
               if (im_ev) begin
                  rm <= m_rm;
                  lm <= m_lm;
               end
               if (ih_ev) begin
                  rh   <= h_rh;
                  lh   <= h_lh;
                  pm_q <= h_pm;
               end
               if (!bus.set_mode) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_minute_hour_counter.sv
// Scoreboard bench for minute_hour_counter, 12h and 24h instances in lockstep.
// A plain hours/minutes model predicts both displays each cycle.
module tb_minute_hour_counter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   minute_hour_counter_if if12 ();
   minute_hour_counter_if if24 ();

   minute_hour_counter #(.MODE_24H(1'b0)) dut12 (
      .clk (clk),
      .rst (rst),
      .bus (if12.slave)
   );

   minute_hour_counter #(.MODE_24H(1'b1)) dut24 (
      .clk (clk),
      .rst (rst),
      .bus (if24.slave)
   );

   typedef struct packed {
      logic [17:0] e12;
      logic [17:0] e24;
   } exp_t;

   exp_t sb_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   int   m_hr, m_mn;
   logic m_set, m_day, p_cm, p_im, p_ih;

   task automatic chk(input string tag, input logic [17:0] got,
                      input logic [17:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (hh:hh:mm:mm:pm:day)",
                  tag, got, exp);
      end
   endtask

   function automatic logic [17:0] pk12(int hr, int mn, logic day);
      int h;
      h = (hr % 12 == 0) ? 12 : hr % 12;
      return {4'(h / 10), 4'(h % 10), 4'(mn / 10), 4'(mn % 10),
              (hr >= 12), day};
   endfunction

   function automatic logic [17:0] pk24(int hr, int mn, logic day);
      return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10),
              1'b0, day};
   endfunction

   task automatic model(input logic r, cm, sm, im, ih);
      if (!r) begin
         m_hr = 0; m_mn = 0; m_set = 0; m_day = 0;
         p_cm = 0; p_im = 0; p_ih = 0;
         return;
      end
      m_day = 0;
      if (!m_set) begin
         if (cm && !p_cm) begin
            m_mn++;
            if (m_mn == 60) begin
               m_mn = 0;
               m_hr = (m_hr + 1) % 24;
               if (m_hr == 0) m_day = 1;
            end
         end
      end else begin
         if (im && !p_im) m_mn = (m_mn + 1) % 60;
         if (ih && !p_ih) m_hr = (m_hr + 1) % 24;
      end
      m_set = sm;
      p_cm = cm; p_im = im; p_ih = ih;
   endtask

   function automatic logic [17:0] obs12();
      return {if12.left_hr, if12.right_hr, if12.left_min,
              if12.right_min, if12.pm, if12.change_day};
   endfunction

   function automatic logic [17:0] obs24();
      return {if24.left_hr, if24.right_hr, if24.left_min,
              if24.right_min, if24.pm, if24.change_day};
   endfunction

   task automatic step(input string tag, input logic r, cm, sm, im, ih);
      exp_t e;
      rst = r;
      if12.change_minute = cm; if24.change_minute = cm;
      if12.set_mode      = sm; if24.set_mode      = sm;
      if12.inc_min       = im; if24.inc_min       = im;
      if12.inc_hr        = ih; if24.inc_hr        = ih;
      model(r, cm, sm, im, ih);
      e.e12 = pk12(m_hr, m_mn, m_day);
      e.e24 = pk24(m_hr, m_mn, m_day);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_12h"}, obs12(), e.e12);
         chk({tag, "_24h"}, obs24(), e.e24);
      end
   endtask

   task automatic pulses(input string tag, input int n, input logic sm,
                         input logic cm, im, ih);
      for (int i = 0; i < n; i++) begin
         step(tag, 1'b1, cm, sm, im, ih);
         step(tag, 1'b1, 1'b0, sm, 1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic preload_1159();
      step("enter_set", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      pulses("set_hr", 11, 1'b1, 1'b0, 1'b0, 1'b1);
      pulses("set_min", 59, 1'b1, 1'b0, 1'b1, 1'b0);
      step("exit_set", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      do_reset();
      pulses("run_min", 60, 1'b0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++)
         step("hold_cm", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("hold_cm", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // run-mode buttons must not move anything
      pulses("run_btn", 3, 1'b0, 1'b0, 1'b1, 1'b1);

      do_reset();
      preload_1159();
      pulses("noon", 1, 1'b0, 1'b1, 1'b0, 1'b0);

      preload_1159();
      pulses("midnight", 1, 1'b0, 1'b1, 1'b0, 1'b0);

      step("enter_set", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      pulses("set_min61", 61, 1'b1, 1'b0, 1'b1, 1'b0);
      pulses("set_cm", 2, 1'b1, 1'b1, 1'b0, 1'b0);
      pulses("set_both", 3, 1'b1, 1'b0, 1'b1, 1'b1);

      step("rst_in_set", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      pulses("after_rst", 2, 1'b0, 1'b1, 1'b0, 1'b0);

      // transition cycles with simultaneous events
      step("tr_run", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step("tr_set", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("tr_set2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step("tr_exit", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 600; i++)
         step("random", ($urandom_range(0, 99) != 0),
              1'($urandom), ($urandom_range(0, 3) == 0),
              1'($urandom), 1'($urandom));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
